qtable_neighbor_engine: RTL and testbench

- Parametrised successor to the single-entry Q-table updater. Owns the neighbour table and the known-cluster-head (CH) list internally, instead of streaming entries to external memory.
- Per received packet: searches the neighbour table by source ID, then updates the matching entry or appends a new one. Next, searches the CH list and appends the CH if it is unknown.
- Sits between the packet parser and the routing/CH-selection logic. Start/done handshake on the packet side, combinational read ports on the consumer side.

---
 rtl/qtable_neighbor_engine.sv | 218 +++++++++++++++++++++
 tb/tb_qtable_neighbor_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/qtable_neighbor_engine.sv
// rtl/qtable_neighbor_engine.sv - neighbour table and known-CH list owner with per-packet search/update
// Optional full-table replacement of the lowest-q entry: define QTNE_REPLACE_EN.
module qtable_neighbor_engine #(
    parameter int ID_W      = 16,
    parameter int DATA_W    = 16,
    parameter int NBR_DEPTH = 8,
    parameter int CH_DEPTH  = 4,
    parameter int CNT_W     = $clog2(NBR_DEPTH + 1),
    parameter int CCNT_W    = $clog2(CH_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [ID_W-1:0]   f_src_id,
    input  logic [DATA_W-1:0] f_hops,
    input  logic [ID_W-1:0]   f_cid,
    input  logic [DATA_W-1:0] f_energy,
    input  logic [DATA_W-1:0] f_q,
    input  logic [ID_W-1:0]   f_ch_id,
    input  logic              f_ch_valid,
    output logic              busy,
    output logic              done,
    output logic              res_added,
    output logic              res_updated,
    output logic              res_drop,
    output logic              ch_added,
    output logic [CNT_W-1:0]  nbr_count,
    output logic [CCNT_W-1:0] ch_count,
    input  logic [CNT_W-1:0]  rd_idx,
    output logic [ID_W-1:0]   rd_id,
    output logic [DATA_W-1:0] rd_hops,
    output logic [ID_W-1:0]   rd_cid,
    output logic [DATA_W-1:0] rd_energy,
    output logic [DATA_W-1:0] rd_q,
    input  logic [CCNT_W-1:0] ch_rd_idx,
    output logic [ID_W-1:0]   ch_rd_id
);

    localparam int NAW = (NBR_DEPTH > 1) ? $clog2(NBR_DEPTH) : 1;
    localparam int CAW = (CH_DEPTH > 1) ? $clog2(CH_DEPTH) : 1;
    localparam logic [CNT_W-1:0]  NBR_FULL = CNT_W'(NBR_DEPTH);
    localparam logic [CCNT_W-1:0] CH_FULL  = CCNT_W'(CH_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN_NBR, S_WRITE_NBR, S_SCAN_CH, S_WRITE_CH, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CCNT_W-1:0]   cidx_q, cidx_d;
    logic                found_q, found_d;
    logic [ID_W-1:0]     p_src_q, p_src_d, p_cid_q, p_cid_d, p_ch_q, p_ch_d;
    logic [DATA_W-1:0]   p_hops_q, p_hops_d, p_energy_q, p_energy_d, p_qv_q, p_qv_d;
    logic                p_chv_q, p_chv_d;
    logic [ID_W-1:0]     nbr_id_q [NBR_DEPTH], nbr_id_d [NBR_DEPTH];
    logic [DATA_W-1:0]   nbr_hops_q [NBR_DEPTH], nbr_hops_d [NBR_DEPTH];
    logic [ID_W-1:0]     nbr_cid_q [NBR_DEPTH], nbr_cid_d [NBR_DEPTH];
    logic [DATA_W-1:0]   nbr_energy_q [NBR_DEPTH], nbr_energy_d [NBR_DEPTH];
    logic [DATA_W-1:0]   nbr_qv_q [NBR_DEPTH], nbr_qv_d [NBR_DEPTH];
    logic [ID_W-1:0]     ch_id_q [CH_DEPTH], ch_id_d [CH_DEPTH];
    logic [CNT_W-1:0]    nbr_count_q, nbr_count_d;
    logic [CCNT_W-1:0]   ch_count_q, ch_count_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                added_q, added_d, updated_q, updated_d, drop_q, drop_d, ch_added_q, ch_added_d;
`ifdef QTNE_REPLACE_EN
    logic [NAW-1:0]      min_idx_q, min_idx_d;
    logic [DATA_W-1:0]   min_qv_q, min_qv_d;
`endif

    logic [NAW-1:0] idx_a, cnt_a;
    logic [CAW-1:0] cidx_a, ccnt_a;
    assign idx_a  = idx_q[NAW-1:0];
    assign cnt_a  = nbr_count_q[NAW-1:0];
    assign cidx_a = cidx_q[CAW-1:0];
    assign ccnt_a = ch_count_q[CAW-1:0];

    always_comb begin
        state_d = state_q;  idx_d = idx_q;  cidx_d = cidx_q;  found_d = found_q;
        p_src_d = p_src_q;  p_hops_d = p_hops_q;  p_cid_d = p_cid_q;
        p_energy_d = p_energy_q;  p_qv_d = p_qv_q;  p_ch_d = p_ch_q;  p_chv_d = p_chv_q;
        nbr_id_d = nbr_id_q;  nbr_hops_d = nbr_hops_q;  nbr_cid_d = nbr_cid_q;
        nbr_energy_d = nbr_energy_q;  nbr_qv_d = nbr_qv_q;  ch_id_d = ch_id_q;
        nbr_count_d = nbr_count_q;  ch_count_d = ch_count_q;
        added_d = added_q;  updated_d = updated_q;  drop_d = drop_q;  ch_added_d = ch_added_q;
`ifdef QTNE_REPLACE_EN
        min_idx_d = min_idx_q;  min_qv_d = min_qv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p_src_d = f_src_id;  p_hops_d = f_hops;  p_cid_d = f_cid;
                    p_energy_d = f_energy;  p_qv_d = f_q;  p_ch_d = f_ch_id;  p_chv_d = f_ch_valid;
                    added_d = 1'b0;  updated_d = 1'b0;  drop_d = 1'b0;  ch_added_d = 1'b0;
                    idx_d = '0;  cidx_d = '0;  found_d = 1'b0;
                    state_d = S_SCAN_NBR;
                end
            end
            S_SCAN_NBR: begin
                if (idx_q == nbr_count_q) begin
                    found_d = 1'b0;
                    state_d = S_WRITE_NBR;
                end else begin
`ifdef QTNE_REPLACE_EN
                    // Strict less-than keeps the lowest index on ties.
                    if (idx_q == '0 || nbr_qv_q[idx_a] < min_qv_q) begin
                        min_idx_d = idx_a;
                        min_qv_d  = nbr_qv_q[idx_a];
                    end
`endif
                    if (nbr_id_q[idx_a] == p_src_q) begin
                        found_d = 1'b1;
                        state_d = S_WRITE_NBR;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_WRITE_NBR: begin
                if (found_q) begin
                    nbr_cid_d[idx_a]    = p_cid_q;
                    nbr_energy_d[idx_a] = p_energy_q;
                    nbr_qv_d[idx_a]     = p_qv_q;
                    if (p_hops_q < nbr_hops_q[idx_a]) nbr_hops_d[idx_a] = p_hops_q;
                    updated_d = 1'b1;
                end else if (nbr_count_q < NBR_FULL) begin
                    nbr_id_d[cnt_a] = p_src_q;  nbr_hops_d[cnt_a] = p_hops_q;
                    nbr_cid_d[cnt_a] = p_cid_q;  nbr_energy_d[cnt_a] = p_energy_q;
                    nbr_qv_d[cnt_a] = p_qv_q;
                    nbr_count_d = nbr_count_q + 1'b1;
                    added_d = 1'b1;
                end else begin
`ifdef QTNE_REPLACE_EN
                    if (p_qv_q > min_qv_q) begin
                        nbr_id_d[min_idx_q] = p_src_q;  nbr_hops_d[min_idx_q] = p_hops_q;
                        nbr_cid_d[min_idx_q] = p_cid_q;  nbr_energy_d[min_idx_q] = p_energy_q;
                        nbr_qv_d[min_idx_q] = p_qv_q;
                        added_d = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
`else
                    drop_d = 1'b1;
`endif
                end
                state_d = p_chv_q ? S_SCAN_CH : S_DONE;
            end
            S_SCAN_CH: begin
                if (cidx_q == ch_count_q) begin
                    state_d = (ch_count_q < CH_FULL) ? S_WRITE_CH : S_DONE;
                end else if (ch_id_q[cidx_a] == p_ch_q) begin
                    state_d = S_DONE;
                end else begin
                    cidx_d = cidx_q + 1'b1;
                end
            end
            S_WRITE_CH: begin
                ch_id_d[ccnt_a] = p_ch_q;
                ch_count_d = ch_count_q + 1'b1;
                ch_added_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;  idx_q <= '0;  cidx_q <= '0;  found_q <= 1'b0;
            p_src_q <= '0;  p_hops_q <= '0;  p_cid_q <= '0;  p_energy_q <= '0;
            p_qv_q <= '0;  p_ch_q <= '0;  p_chv_q <= 1'b0;
            nbr_id_q <= '{default: '0};  nbr_hops_q <= '{default: '0};
            nbr_cid_q <= '{default: '0};  nbr_energy_q <= '{default: '0};
            nbr_qv_q <= '{default: '0};  ch_id_q <= '{default: '0};
            nbr_count_q <= '0;  ch_count_q <= '0;
            busy_q <= 1'b0;  done_q <= 1'b0;
            added_q <= 1'b0;  updated_q <= 1'b0;  drop_q <= 1'b0;  ch_added_q <= 1'b0;
`ifdef QTNE_REPLACE_EN
            min_idx_q <= '0;  min_qv_q <= '0;
`endif
        end else begin
            state_q <= state_d;  idx_q <= idx_d;  cidx_q <= cidx_d;  found_q <= found_d;
            p_src_q <= p_src_d;  p_hops_q <= p_hops_d;  p_cid_q <= p_cid_d;  p_energy_q <= p_energy_d;
            p_qv_q <= p_qv_d;  p_ch_q <= p_ch_d;  p_chv_q <= p_chv_d;
            nbr_id_q <= nbr_id_d;  nbr_hops_q <= nbr_hops_d;
            nbr_cid_q <= nbr_cid_d;  nbr_energy_q <= nbr_energy_d;
            nbr_qv_q <= nbr_qv_d;  ch_id_q <= ch_id_d;
            nbr_count_q <= nbr_count_d;  ch_count_q <= ch_count_d;
            busy_q <= busy_d;  done_q <= done_d;
            added_q <= added_d;  updated_q <= updated_d;  drop_q <= drop_d;  ch_added_q <= ch_added_d;
`ifdef QTNE_REPLACE_EN
            min_idx_q <= min_idx_d;  min_qv_q <= min_qv_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign res_added   = added_q;
    assign res_updated = updated_q;
    assign res_drop    = drop_q;
    assign ch_added    = ch_added_q;
    assign nbr_count   = nbr_count_q;
    assign ch_count    = ch_count_q;

    logic rd_ok, ch_rd_ok;
    assign rd_ok     = (rd_idx < nbr_count_q);
    assign ch_rd_ok  = (ch_rd_idx < ch_count_q);
    assign rd_id     = rd_ok ? nbr_id_q[rd_idx[NAW-1:0]] : '0;
    assign rd_hops   = rd_ok ? nbr_hops_q[rd_idx[NAW-1:0]] : '0;
    assign rd_cid    = rd_ok ? nbr_cid_q[rd_idx[NAW-1:0]] : '0;
    assign rd_energy = rd_ok ? nbr_energy_q[rd_idx[NAW-1:0]] : '0;
    assign rd_q      = rd_ok ? nbr_qv_q[rd_idx[NAW-1:0]] : '0;
    assign ch_rd_id  = ch_rd_ok ? ch_id_q[ch_rd_idx[CAW-1:0]] : '0;

endmodule

// File: tb/tb_qtable_neighbor_engine.sv
// tb/tb_qtable_neighbor_engine.sv - table-driven bench for qtable_neighbor_engine
module tb_qtable_neighbor_engine;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] f_src_id = '0, f_hops = '0, f_cid = '0, f_energy = '0, f_q = '0, f_ch_id = '0;
    logic        f_ch_valid = 1'b0;
    logic        busy, done, res_added, res_updated, res_drop, ch_added;
    logic [3:0]  nbr_count, rd_idx = '0;
    logic [2:0]  ch_count, ch_rd_idx = '0;
    logic [15:0] rd_id, rd_hops, rd_cid, rd_energy, rd_q, ch_rd_id;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    qtable_neighbor_engine dut (
        .clk(clk), .nrst(nrst), .start(start),
        .f_src_id(f_src_id), .f_hops(f_hops), .f_cid(f_cid), .f_energy(f_energy),
        .f_q(f_q), .f_ch_id(f_ch_id), .f_ch_valid(f_ch_valid),
        .busy(busy), .done(done), .res_added(res_added), .res_updated(res_updated),
        .res_drop(res_drop), .ch_added(ch_added), .nbr_count(nbr_count), .ch_count(ch_count),
        .rd_idx(rd_idx), .rd_id(rd_id), .rd_hops(rd_hops), .rd_cid(rd_cid),
        .rd_energy(rd_energy), .rd_q(rd_q), .ch_rd_idx(ch_rd_idx), .ch_rd_id(ch_rd_id)
    );

    typedef struct {
        logic [15:0] src, hops, cid, energy, q, ch;
        logic        chv;
        logic        add, upd, drp, cha;
        int          ncnt, ccnt, lat;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept edge is edge 0; returns the edge after which done is first seen high.
    task automatic run_pkt(input vec_t v, output int lat);
        f_src_id = v.src;  f_hops = v.hops;  f_cid = v.cid;  f_energy = v.energy;
        f_q = v.q;  f_ch_id = v.ch;  f_ch_valid = v.chv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int pulses;
        vecs[0]  = '{16'h0005, 16'd3, 16'h11, 16'h50, 16'h0100, 16'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 4};
        vecs[1]  = '{16'h0005, 16'd2, 16'h12, 16'h60, 16'h0200, 16'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 3};
        vecs[2]  = '{16'h0005, 16'd7, 16'h13, 16'h70, 16'h0300, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 2};
        vecs[3]  = '{16'h0000, 16'd1, 16'h21, 16'h30, 16'h0080, 16'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 2, 6};
        vecs[4]  = '{16'h0010, 16'd4, 16'h01, 16'h01, 16'h0500, 16'h4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 3, 8};
        vecs[5]  = '{16'h0011, 16'd4, 16'h01, 16'h01, 16'h0500, 16'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4, 4, 10};
        vecs[6]  = '{16'h0012, 16'd4, 16'h01, 16'h01, 16'h0500, 16'h6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5, 4, 11};
        vecs[7]  = '{16'h0013, 16'd4, 16'h01, 16'h01, 16'h0500, 16'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6, 4, 8};
        vecs[8]  = '{16'h0014, 16'd4, 16'h01, 16'h01, 16'h0500, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7, 4, 8};
        vecs[9]  = '{16'h0015, 16'd4, 16'h01, 16'h01, 16'h0500, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 4, 9};
`ifdef QTNE_REPLACE_EN
        vecs[10] = '{16'h0020, 16'd1, 16'h01, 16'h01, 16'h0400, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 4, 10};
        vecs[11] = '{16'h0020, 16'd1, 16'h01, 16'h01, 16'h0400, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8, 4, 3};
        vecs[13] = '{16'h0000, 16'd1, 16'h01, 16'h01, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8, 4, 10};
`else
        vecs[10] = '{16'h0020, 16'd1, 16'h01, 16'h01, 16'h0400, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8, 4, 10};
        vecs[11] = '{16'h0020, 16'd1, 16'h01, 16'h01, 16'h0400, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8, 4, 10};
        vecs[13] = '{16'h0000, 16'd1, 16'h01, 16'h01, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8, 4, 3};
`endif
        vecs[12] = '{16'h0015, 16'd4, 16'h01, 16'h01, 16'h0500, 16'h4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8, 4, 12};

        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_nbr_count", nbr_count, 0);
        chk("reset_ch_count", ch_count, 0);
        chk("reset_flags", {res_added, res_updated, res_drop, ch_added}, 0);
        chk("reset_rd_id", rd_id, 0);

        for (int n = 0; n < 14; n++) begin
            run_pkt(vecs[n], lat);
            chk($sformatf("v%0d_latency", n), lat, vecs[n].lat);
            chk($sformatf("v%0d_flags", n), {res_added, res_updated, res_drop, ch_added},
                {vecs[n].add, vecs[n].upd, vecs[n].drp, vecs[n].cha});
            chk($sformatf("v%0d_nbr_count", n), nbr_count, vecs[n].ncnt);
            chk($sformatf("v%0d_ch_count", n), ch_count, vecs[n].ccnt);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", n), {busy, done}, 0);
            chk($sformatf("v%0d_flags_held", n), {res_added, res_updated, res_drop, ch_added},
                {vecs[n].add, vecs[n].upd, vecs[n].drp, vecs[n].cha});
        end

        rd_idx = 4'd0; #1;
        chk("rd0_id", rd_id, 16'h0005);
        chk("rd0_hops_min", rd_hops, 2);
        chk("rd0_cid", rd_cid, 16'h13);
        chk("rd0_energy", rd_energy, 16'h70);
        chk("rd0_q", rd_q, 16'h0300);
        rd_idx = 4'd1; #1;
`ifdef QTNE_REPLACE_EN
        chk("rd1_id", rd_id, 16'h0020);
        chk("rd1_q", rd_q, 16'h0400);
`else
        chk("rd1_id", rd_id, 16'h0000);
        chk("rd1_q", rd_q, 16'h0010);
`endif
        rd_idx = 4'd7; #1;
        chk("rd7_id", rd_id, 16'h0015);
        rd_idx = 4'd8; #1;
        chk("rd8_out_of_range", rd_id, 0);
        for (int c = 0; c < 5; c++) begin
            ch_rd_idx = 3'(c); #1;
            chk($sformatf("ch_rd%0d", c), ch_rd_id, (c == 0) ? 2 : (c < 4) ? c + 2 : 0);
        end
        rd_idx = 4'd0;

        // Reset during SCAN_NBR discards everything.
        f_src_id = 16'h0077;  f_ch_valid = 1'b0;  f_q = 16'h0001;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        chk("midreset_nbr_count", nbr_count, 0);
        chk("midreset_ch_count", ch_count, 0);
        chk("midreset_busy_done", {busy, done}, 0);
        chk("midreset_rd_id", rd_id, 0);
        ch_rd_idx = 3'd0; #1;
        chk("midreset_ch_rd", ch_rd_id, 0);

        // start while busy and input churn must be ignored.
        f_src_id = 16'h0007;  f_hops = 16'd9;  f_ch_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_accept", busy, 1);
        f_src_id = 16'h0009;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) pulses++;
        end
        chk("single_done_pulse", pulses, 1);
        chk("busy_start_count", nbr_count, 1);
        chk("busy_start_rd_id", rd_id, 16'h0007);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
